// File: rtl/mem_io_resp_if.sv
// rtl/mem_io_resp_if.sv - core-side byte memory port and transmit stream bundle
//
// Signals:
//   rom_a/rom_wr/rom_wn  byte request from the core (address, write strobe, write data)
//   rom_rn               registered read data back to the core
//   tx_data/tx_valid     transmit FIFO head on a ready/valid stream
//   tx_ready             consumer acceptance of the FIFO head
//   tx_ovf               sticky flag for a push dropped on a full FIFO
//   sim_end/sim_code     sticky end-of-simulation flag and its code byte
// Modports: master = core/consumer side, slave = mem_io_resp.

interface mem_io_resp_if;
  logic [31:0] rom_a;
  logic        rom_wr;
  logic [7:0]  rom_wn;
  logic [7:0]  rom_rn;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_ovf;
  logic        sim_end;
  logic [7:0]  sim_code;

  modport master (
    output rom_a, rom_wr, rom_wn, tx_ready,
    input  rom_rn, tx_data, tx_valid, tx_ovf, sim_end, sim_code
  );

  modport slave (
    input  rom_a, rom_wr, rom_wn, tx_ready,
    output rom_rn, tx_data, tx_valid, tx_ovf, sim_end, sim_code
  );
endinterface

// File: rtl/mem_io_resp.sv
// rtl/mem_io_resp.sv - byte RAM plus memory-mapped transmit FIFO and sim-end register
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  mem_io_resp_if.slave (core request/response, tx stream, status flags)
// Address map: rom_a[17:16]==2'b11 selects IO (offset 0x0000 = tx push / reads 0,
// offset 0x0004 = sim-end write / status read), everything else is RAM indexed
// by rom_a[ADDR_W-1:0]. Upper address bits alias.

module mem_io_resp #(
  parameter int    ADDR_W     = 17,
  parameter int    FIFO_DEPTH = 16,
  parameter string INIT_FILE  = "test.data"
) (
  input logic          clk,
  input logic          rst,
  mem_io_resp_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [7:0] mem      [0:(1 << ADDR_W) - 1];
  logic [7:0] fifo_mem [0:FIFO_DEPTH - 1];

  logic [7:0]   rom_rn_q,   rom_rn_d;
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic         tx_ovf_q,   tx_ovf_d;
  logic         sim_end_q,  sim_end_d;
  logic [7:0]   sim_code_q, sim_code_d;

  logic [ADDR_W-1:0] ram_idx;
  logic [15:0]       io_off;
  logic              io_sel;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push_req;
  logic              push;
  logic              ram_we;
  logic              unused_addr;

  assign unused_addr = ^bus.rom_a;

  assign ram_idx    = bus.rom_a[ADDR_W-1:0];
  assign io_off     = bus.rom_a[15:0];
  assign io_sel     = (bus.rom_a[17:16] == 2'b11);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                      (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign pop        = !fifo_empty && bus.tx_ready;
  assign push_req   = io_sel && bus.rom_wr && (io_off == 16'h0000);
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);
  assign ram_we     = !io_sel && bus.rom_wr;

  always_comb begin
    rom_rn_d   = rom_rn_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_ovf_d   = tx_ovf_q;
    sim_end_d  = sim_end_q;
    sim_code_d = sim_code_q;

    if (!bus.rom_wr) begin
      if (io_sel) begin
        rom_rn_d = (io_off == 16'h0004) ? {6'b0, fifo_full, fifo_empty} : 8'h00;
      end else begin
        rom_rn_d = mem[ram_idx];
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_req && fifo_full && !pop) tx_ovf_d = 1'b1;

    // First write to the end register wins so the original exit code survives.
    if (io_sel && bus.rom_wr && (io_off == 16'h0004) && !sim_end_q) begin
      sim_end_d  = 1'b1;
      sim_code_d = bus.rom_wn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_rn_q   <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_ovf_q   <= 1'b0;
      sim_end_q  <= 1'b0;
      sim_code_q <= 8'h00;
    end else begin
      rom_rn_q   <= rom_rn_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_ovf_q   <= tx_ovf_d;
      sim_end_q  <= sim_end_d;
      sim_code_q <= sim_code_d;
    end
  end

  // Storage arrays are not reset; RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= bus.rom_wn;
    if (push)   fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.rom_wn;
  end

  assign bus.rom_rn   = rom_rn_q;
  // Gate the head so stale or uninitialised FIFO entries never reach tx_data.
  assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_ovf   = tx_ovf_q;
  assign bus.sim_end  = sim_end_q;
  assign bus.sim_code = sim_code_q;

endmodule

// File: tb/tb_mem_io_resp.sv
// tb/tb_mem_io_resp.sv - scoreboard bench for mem_io_resp

module tb_mem_io_resp;

  logic clk;
  logic rst;
  mem_io_resp_if bus ();

  mem_io_resp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rd_q [$];
  logic [7:0] tx_q [$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    bus.rom_a  = a;
    bus.rom_wr = 1'b1;
    bus.rom_wn = d;
    tick();
    bus.rom_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
    bus.rom_a  = a;
    bus.rom_wr = 1'b0;
    tick();
    d = bus.rom_rn;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    n_cmp++; if (bus.rom_rn !== 8'h00) begin n_err++; $display("FAIL reset_rom_rn got=%h exp=00", bus.rom_rn); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
    n_cmp++; if (bus.sim_end !== 1'b0) begin n_err++; $display("FAIL reset_sim_end got=%b exp=0", bus.sim_end); end
    n_cmp++; if (bus.tx_ovf !== 1'b0) begin n_err++; $display("FAIL reset_tx_ovf got=%b exp=0", bus.tx_ovf); end
  endtask

  task automatic test_ram_rw();
    logic [7:0] got, exp;
    bus_write(32'h0000_0010, 8'hA5);
    rd_q.push_back(8'hA5);
    bus_read(32'h0000_0010, got);
    exp = rd_q.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL ram_raw got=%h exp=%h", got, exp); end
    // A write must leave rom_rn untouched.
    bus_write(32'h0000_0020, 8'h11);
    n_cmp++; if (bus.rom_rn !== 8'hA5) begin n_err++; $display("FAIL ram_hold_on_write got=%h exp=a5", bus.rom_rn); end
    bus_write(32'h0000_0011, 8'h3C);
    rd_q.push_back(8'h3C);
    bus_read(32'h0000_0011, got);
    exp = rd_q.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL ram_byte11 got=%h exp=%h", got, exp); end
    // Upper bits alias: 0xFFFC0010 has [17:16]=00 and index 0x10.
    rd_q.push_back(8'hA5);
    bus_read(32'hFFFC_0010, got);
    exp = rd_q.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL ram_alias got=%h exp=%h", got, exp); end
    rd_q.push_back(8'h11);
    bus_read(32'h0000_0020, got);
    exp = rd_q.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL ram_byte20 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_tx_stream();
    logic [7:0] got;
    bus.tx_ready = 1'b0;
    bus_write(32'h0003_0000, 8'h48); tx_q.push_back(8'h48);
    bus_write(32'h0003_0000, 8'h69); tx_q.push_back(8'h69);
    n_cmp++; if (bus.tx_valid !== 1'b1) begin n_err++; $display("FAIL tx_valid_queued got=%b exp=1", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== tx_q[0]) begin n_err++; $display("FAIL tx_head got=%h exp=%h", bus.tx_data, tx_q[0]); end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== tx_q[0]) begin
        n_err++; $display("FAIL tx_drain%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, tx_q[0]);
      end
      tick();
      void'(tx_q.pop_front());
    end
    bus.tx_ready = 1'b0;
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_empty_after got=%b exp=0", bus.tx_valid); end
    rd_q.push_back(8'h01);
    bus_read(32'h0003_0004, got);
    n_cmp++; if (got !== rd_q[0]) begin n_err++; $display("FAIL status_empty got=%h exp=%h", got, rd_q[0]); end
    void'(rd_q.pop_front());
    rd_q.push_back(8'h00);
    bus_read(32'h0003_0000, got);
    n_cmp++; if (got !== rd_q[0]) begin n_err++; $display("FAIL tx_port_read got=%h exp=%h", got, rd_q[0]); end
    void'(rd_q.pop_front());
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus_write(32'h0003_0000, 8'h10 + 8'(i));
      tx_q.push_back(8'h10 + 8'(i));
    end
    n_cmp++; if (bus.tx_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_at_full got=%b exp=0", bus.tx_ovf); end
    bus_read(32'h0003_0004, got);
    n_cmp++; if (got !== 8'h02) begin n_err++; $display("FAIL status_full got=%h exp=02", got); end
    // Full FIFO: push and pop in the same cycle.
    n_cmp++; if (bus.tx_data !== tx_q[0]) begin n_err++; $display("FAIL full_head got=%h exp=%h", bus.tx_data, tx_q[0]); end
    bus.tx_ready = 1'b1;
    bus_write(32'h0003_0000, 8'hEE);
    bus.tx_ready = 1'b0;
    void'(tx_q.pop_front());
    tx_q.push_back(8'hEE);
    n_cmp++; if (bus.tx_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_push_pop got=%b exp=0", bus.tx_ovf); end
    n_cmp++; if (bus.tx_data !== tx_q[0]) begin n_err++; $display("FAIL head_after_push_pop got=%h exp=%h", bus.tx_data, tx_q[0]); end
    bus_read(32'h0003_0004, got);
    n_cmp++; if (got !== 8'h02) begin n_err++; $display("FAIL status_still_full got=%h exp=02", got); end
    // Push into a full FIFO with no pop is dropped.
    bus_write(32'h0003_0000, 8'hDD);
    n_cmp++; if (bus.tx_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", bus.tx_ovf); end
    bus_read(32'h0003_0004, got);
    n_cmp++; if (got !== 8'h02) begin n_err++; $display("FAIL status_ovf got=%h exp=02", got); end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== tx_q[0]) begin
        n_err++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, tx_q[0]);
      end
      tick();
      void'(tx_q.pop_front());
    end
    bus.tx_ready = 1'b0;
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained got=%b exp=0", bus.tx_valid); end
    n_cmp++; if (bus.tx_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", bus.tx_ovf); end
  endtask

  task automatic test_sim_end();
    n_cmp++; if (bus.sim_end !== 1'b0) begin n_err++; $display("FAIL sim_end_idle got=%b exp=0", bus.sim_end); end
    bus_write(32'h0003_0004, 8'h07);
    n_cmp++; if (bus.sim_end !== 1'b1 || bus.sim_code !== 8'h07) begin
      n_err++; $display("FAIL sim_end_first got=%b/%h exp=1/07", bus.sim_end, bus.sim_code);
    end
    bus_write(32'h0003_0004, 8'h09);
    n_cmp++; if (bus.sim_end !== 1'b1 || bus.sim_code !== 8'h07) begin
      n_err++; $display("FAIL sim_end_second got=%b/%h exp=1/07", bus.sim_end, bus.sim_code);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] got;
    bus_write(32'h0000_0040, 8'h5A);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_write(32'h0003_0000, 8'hC0 + 8'(i));
      tx_q.push_back(8'hC0 + 8'(i));
    end
    bus.rom_a = 32'h0003_0000;
    n_cmp++; if (bus.tx_valid !== 1'b1) begin n_err++; $display("FAIL mid_queued got=%b exp=1", bus.tx_valid); end
    bus.tx_ready = 1'b1;
    @(posedge clk);
    void'(tx_q.pop_front());
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got=%b exp=0", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL mid_async_data got=%h exp=00", bus.tx_data); end
    tx_q.delete();
    bus.tx_ready = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_post_valid got=%b exp=0", bus.tx_valid); end
    n_cmp++; if (bus.tx_ovf !== 1'b0 || bus.sim_end !== 1'b0 || bus.sim_code !== 8'h00) begin
      n_err++; $display("FAIL mid_post_flags got=%b/%b/%h exp=0/0/00", bus.tx_ovf, bus.sim_end, bus.sim_code);
    end
    rd_q.push_back(8'h5A);
    bus_read(32'h0000_0040, got);
    n_cmp++; if (got !== rd_q[0]) begin n_err++; $display("FAIL mid_ram_kept got=%h exp=%h", got, rd_q[0]); end
    void'(rd_q.pop_front());
    bus_read(32'h0003_0004, got);
    n_cmp++; if (got !== 8'h01) begin n_err++; $display("FAIL mid_status got=%h exp=01", got); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    bus.rom_a    = 32'h0003_0000;
    bus.rom_wr   = 1'b0;
    bus.rom_wn   = 8'h00;
    bus.tx_ready = 1'b0;
    test_reset();
    test_ram_rw();
    test_tx_stream();
    test_overflow();
    test_sim_end();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
